// File: rtl/gen_rr_arbiter_pkg.sv
// Shared types for the generator round-robin arbiter.
// Optional statistics/error port build switch: GEN_ARB_STATS_EN.
package gen_arb_pkg;

  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/gen_rr_arbiter_if.sv
// Requester / generator / consumer signal bundle for gen_rr_arbiter.
// slave = arbiter view, master = environment view.
interface gen_rr_arbiter_if
  import gen_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DEFAULT_DATA_W
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_n;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         gen_n;
  logic                      gen_start;
  logic                      gen_ready;
  logic                      gen_valid;
  logic [DATA_W-1:0]         gen_output;
  logic                      gen_done;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic [ID_W-1:0]           out_id;
  logic                      out_ready;
  logic                      out_done;
  logic                      busy;

  modport slave (
    input  req_valid, req_n, gen_valid, gen_output, gen_done, out_ready,
    output req_ready, gen_n, gen_start, gen_ready, out_valid, out_data,
           out_id, out_done, busy
  );

  modport master (
    output req_valid, req_n, gen_valid, gen_output, gen_done, out_ready,
    input  req_ready, gen_n, gen_start, gen_ready, out_valid, out_data,
           out_id, out_done, busy
  );

endinterface

// File: rtl/gen_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping at NUM_REQ. Reusable by other generator schedulers.
module rr_pick #(
  parameter int NUM_REQ = 4,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    id,
  output logic               any
);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;

  // scan NUM_REQ positions starting at ptr, keep the first hit
  always_comb begin
    gnt = '0;
    id  = '0;
    any = 1'b0;
    sum = '0;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
      idx = sum[ID_W-1:0];
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        id       = idx;
      end
    end
  end

endmodule

// File: rtl/gen_rr_arbiter.sv
// Shares one start/ready/valid/done generator among NUM_REQ requesters.
// Optional build switch GEN_ARB_STATS_EN adds out_count and err_sticky.
//
//   state  | meaning
//   IDLE   | waiting for any req_valid; winner accepted here
//   LAUNCH | gen_start pulse, argument already registered on gen_n
//   RUN    | generator stream passed through, tagged with out_id
//   DONE   | out_done pulse for out_id, then back to IDLE
module gen_rr_arbiter
  import gen_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DEFAULT_DATA_W
) (
  input  logic                __clock,
  input  logic                __reset,
  gen_rr_arbiter_if.slave     bus
`ifdef GEN_ARB_STATS_EN
  ,
  output logic [DATA_W-1:0]   out_count,
  output logic                err_sticky
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     out_id_q, out_id_d;
  logic [DATA_W-1:0]   gen_n_q, gen_n_d;

  logic [NUM_REQ-1:0]  pick_gnt;
  logic [ID_W-1:0]     pick_id;
  logic                pick_any;
  logic [DATA_W-1:0]   sel_n;
  logic [ID_W:0]       ptr_inc;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req (bus.req_valid),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .id  (pick_id),
    .any (pick_any)
  );

  // argument of the current winner
  always_comb begin
    sel_n = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) sel_n = bus.req_n[i*DATA_W +: DATA_W];
    end
  end

  // next state, grant latch and pointer advance after each completed call
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    out_id_d = out_id_q;
    gen_n_d  = gen_n_q;
    ptr_inc  = {1'b0, out_id_q} + (ID_W+1)'(1);
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d  = LAUNCH;
          gen_n_d  = sel_n;
          out_id_d = pick_id;
        end
      end
      LAUNCH: state_d = RUN;
      RUN: begin
        if (bus.gen_done) begin
          state_d  = DONE;
          rr_ptr_d = (ptr_inc == (ID_W+1)'(NUM_REQ)) ? '0 : ptr_inc[ID_W-1:0];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state and call-context registers
  always_ff @(posedge __clock) begin
    if (!__reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      out_id_q <= '0;
      gen_n_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      out_id_q <= out_id_d;
      gen_n_q  <= gen_n_d;
    end
  end

  // the grant is combinational so a requester can drop valid right after the accept edge
  assign bus.req_ready = (state_q == IDLE && __reset) ? pick_gnt : '0;
  assign bus.gen_n     = gen_n_q;
  assign bus.gen_start = (state_q == LAUNCH);
  assign bus.out_valid = (state_q == RUN) && bus.gen_valid;
  assign bus.out_data  = bus.gen_output;
  assign bus.gen_ready = (state_q == RUN) ? bus.out_ready : 1'b1;
  assign bus.out_id    = out_id_q;
  assign bus.out_done  = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);

`ifdef GEN_ARB_STATS_EN
  logic [DATA_W-1:0] count_q, count_d;
  logic              err_q, err_d;

  // per-call transfer count and protocol error latch
  always_comb begin
    count_d = count_q;
    if (state_q == IDLE && pick_any) begin
      count_d = '0;
    end else if (bus.out_valid && bus.out_ready) begin
      count_d = count_q + DATA_W'(1);
    end
    err_d = err_q | (bus.gen_valid && bus.gen_done) | (bus.gen_done && state_q != RUN);
  end

  // statistics registers
  always_ff @(posedge __clock) begin
    if (!__reset) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign out_count  = count_q;
  assign err_sticky = err_q;
`endif

endmodule

// File: tb/tb_gen_rr_arbiter.sv
// Scoreboard bench for gen_rr_arbiter: stimulus pushes expectations,
// a negedge monitor pops and compares whenever the DUT presents output.
module tb_gen_rr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gen_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

`ifdef GEN_ARB_STATS_EN
  logic [DATA_W-1:0] out_count;
  logic              err_sticky;
`endif

  gen_rr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .__clock (clk),
    .__reset (rst_n),
    .bus     (bus)
`ifdef GEN_ARB_STATS_EN
    ,
    .out_count  (out_count),
    .err_sticky (err_sticky)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [3:0]  exp_grant[$];
  logic [31:0] exp_arg[$];
  logic [33:0] exp_xfer[$];
  logic [1:0]  exp_done[$];
  int          exp_cnt[$];
  logic [31:0] vals[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // expectations for one complete call using the current vals
  task automatic push_call(input int id, input logic [31:0] arg);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    exp_grant.push_back(oh);
    exp_arg.push_back(arg);
    foreach (vals[i]) exp_xfer.push_back({2'(id), vals[i]});
    exp_done.push_back(2'(id));
    exp_cnt.push_back(vals.size());
  endtask

  task automatic request(input int id, input logic [31:0] arg);
    int t;
    t = 0;
    bus.req_valid[id] = 1'b1;
    bus.req_n[id*32 +: 32] = arg;
    #1;
    while (!bus.req_ready[id] && t < 50) begin
      tick();
      t++;
    end
    check("req_ready_seen", 64'(bus.req_ready[id]), 64'd1);
    tick();
    bus.req_valid[id] = 1'b0;
    check("gen_start_after_accept", 64'(bus.gen_start), 64'd1);
  endtask

  // generator model: wait for start, emit vals honoring gen_ready, pulse done
  task automatic gen_call();
    int t;
    logic xfer;
    t = 0;
    while (!bus.gen_start && t < 50) begin
      tick();
      t++;
    end
    check("gen_start_seen", 64'(bus.gen_start), 64'd1);
    tick();
    tick();
    foreach (vals[i]) begin
      bus.gen_valid  = 1'b1;
      bus.gen_output = vals[i];
      t = 0;
      do begin
        #1;
        xfer = bus.gen_ready;
        tick();
        t++;
      end while (!xfer && t < 50);
    end
    bus.gen_valid = 1'b0;
    bus.gen_done  = 1'b1;
    tick();
    bus.gen_done  = 1'b0;
    check("out_done_after_gen_done", 64'(bus.out_done), 64'd1);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.req_ready != '0) begin
        if (exp_grant.size() == 0) check("grant_unexpected", 64'(bus.req_ready), 64'd0);
        else check("grant", 64'(bus.req_ready), 64'(exp_grant.pop_front()));
      end
      if (bus.gen_start) begin
        if (exp_arg.size() == 0) check("start_unexpected", 64'(bus.gen_n), 64'hdead);
        else check("gen_n", 64'(bus.gen_n), 64'(exp_arg.pop_front()));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_xfer.size() == 0) check("xfer_unexpected", 64'({bus.out_id, bus.out_data}), 64'hdead);
        else check("xfer_id_data", 64'({bus.out_id, bus.out_data}), 64'(exp_xfer.pop_front()));
      end
      if (bus.out_done) begin
        if (exp_done.size() == 0) check("done_unexpected", 64'(bus.out_id), 64'hdead);
        else check("done_id", 64'(bus.out_id), 64'(exp_done.pop_front()));
`ifdef GEN_ARB_STATS_EN
        if (exp_cnt.size() != 0) check("out_count", 64'(out_count), 64'(exp_cnt.pop_front()));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    bus.req_valid  = '0;
    bus.req_n      = '0;
    bus.gen_valid  = 1'b0;
    bus.gen_output = '0;
    bus.gen_done   = 1'b0;
    bus.out_ready  = 1'b1;

    // power-on reset
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_gen_start", 64'(bus.gen_start), 64'd0);
    check("rst_out_done", 64'(bus.out_done), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_gen_n", 64'(bus.gen_n), 64'd0);
    check("rst_out_id", 64'(bus.out_id), 64'd0);
    rst_n = 1'b1;
    tick();

    // single call from requester 2
    vals = '{32'd1, 32'd3, 32'd5};
    push_call(2, 32'd10);
    request(2, 32'd10);
    gen_call();
    check("single_out_id", 64'(bus.out_id), 64'd2);
    tick();

    // back-pressure: value 7 held while consumer stalls
    vals = '{32'd7};
    push_call(1, 32'd20);
    request(1, 32'd20);
    tick();
    bus.out_ready  = 1'b0;
    bus.gen_valid  = 1'b1;
    bus.gen_output = 32'd7;
    repeat (5) begin
      #1;
      check("bp_gen_ready", 64'(bus.gen_ready), 64'd0);
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_out_data", 64'(bus.out_data), 64'd7);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.gen_valid = 1'b0;
    bus.gen_done  = 1'b1;
    tick();
    bus.gen_done  = 1'b0;
    check("bp_out_done", 64'(bus.out_done), 64'd1);
    tick();

    // zero-output call from requester 3
    vals.delete();
    push_call(3, 32'd30);
    request(3, 32'd30);
    gen_call();
    check("zero_out_id", 64'(bus.out_id), 64'd3);
    tick();

    // reset in the middle of RUN abandons the call
    exp_grant.push_back(4'b0001);
    exp_arg.push_back(32'd40);
    request(0, 32'd40);
    tick();
    tick();
    check("midrun_busy_before", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    tick();
    tick();
    check("midrun_busy", 64'(bus.busy), 64'd0);
    check("midrun_gen_start", 64'(bus.gen_start), 64'd0);
    check("midrun_out_done", 64'(bus.out_done), 64'd0);
    check("midrun_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrun_gen_n", 64'(bus.gen_n), 64'd0);
    rst_n = 1'b1;
    tick();

    // round robin with all requesters held, then 1001
    for (int i = 0; i < NUM_REQ; i++) bus.req_n[i*32 +: 32] = 32'd100 + 32'(i);
    vals = '{32'h11};
    for (int k = 0; k < 4; k++) push_call(k, 32'd100 + 32'(k));
    push_call(0, 32'd100);
    push_call(3, 32'd103);
    push_call(0, 32'd100);
    push_call(3, 32'd103);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      gen_call();
      if (k == 3) bus.req_valid = 4'b1001;
      if (k == 7) bus.req_valid = 4'b0000;
    end
    tick();
    tick();

`ifdef GEN_ARB_STATS_EN
    vals = '{32'd7, 32'd8, 32'd9};
    push_call(1, 32'd55);
    request(1, 32'd55);
    gen_call();
    tick();
    check("err_sticky_clear", 64'(err_sticky), 64'd0);
    bus.gen_valid = 1'b1;
    bus.gen_done  = 1'b1;
    tick();
    bus.gen_valid = 1'b0;
    bus.gen_done  = 1'b0;
    check("err_sticky_set", 64'(err_sticky), 64'd1);
    tick();
`endif

    check("left_grant", 64'(exp_grant.size()), 64'd0);
    check("left_arg", 64'(exp_arg.size()), 64'd0);
    check("left_xfer", 64'(exp_xfer.size()), 64'd0);
    check("left_done", 64'(exp_done.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
